imm_extend_pipe: RTL and testbench



---
 rtl/imm_extend_pipe.sv | 101 ++++++++++
 tb/tb_imm_extend_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate generator (I, D, B, CBZ, MOVZ, MOVK) with tag pass-through.
// Optional macro BRANCH_SHIFT_EN: B/CBZ results are left-shifted by 2 (byte offset).
module imm_extend_pipe #(
    parameter int DATA_WIDTH = 64,  // 32 or 64
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  CLK,
    input  logic                  Reset_L,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [25:0]           Imm26,
    input  logic [2:0]            Ctrl,
    input  logic [DATA_WIDTH-1:0] BusOld,
    input  logic [TAG_WIDTH-1:0]  InTag,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_WIDTH-1:0] BusImm,
    output logic [TAG_WIDTH-1:0]  OutTag,
    output logic                  Illegal
);
    logic                  v1_q, v1_d, v2_q, v2_d;
    logic                  s1_adv, s2_adv;
    logic [2:0]            ctrl_q;
    logic [25:0]           imm_q;
    logic [DATA_WIDTH-1:0] old_q;
    logic [TAG_WIDTH-1:0]  tag1_q, tag2_q;
    logic [DATA_WIDTH-1:0] bus_q, bus_d;
    logic                  ill_q, ill_d;
    logic [63:0]           wide, old64;
    logic [1:0]            hw;
    logic [15:0]           hword;

    assign s2_adv   = ~v2_q | OutReady;
    assign s1_adv   = ~v1_q | s2_adv;
    assign v1_d     = s1_adv ? InValid : v1_q;
    assign v2_d     = s2_adv ? v1_q : v2_q;
    assign InReady  = s1_adv;
    assign OutValid = v2_q;
    assign BusImm   = bus_q;
    assign OutTag   = tag2_q;
    assign Illegal  = ill_q;

    // Formats are built at 64 bits and truncated, which gives the B/CBZ wrap for free.
    always_comb begin
        wide  = '0;
        ill_d = 1'b0;
        hw    = imm_q[22:21];
        hword = imm_q[20:5];
        old64 = 64'(old_q);
        case (ctrl_q)
            3'b000: wide = {52'b0, imm_q[21:10]};
            3'b001: wide = {{55{imm_q[20]}}, imm_q[20:12]};
            3'b010: wide = {{38{imm_q[25]}}, imm_q};
            3'b011: wide = {{45{imm_q[23]}}, imm_q[23:5]};
            3'b100: wide[{hw, 4'b0000} +: 16] = hword;
            3'b101: begin
                wide = old64;
                wide[{hw, 4'b0000} +: 16] = hword;
            end
            default: ill_d = 1'b1;
        endcase
`ifdef BRANCH_SHIFT_EN
        if (ctrl_q == 3'b010 || ctrl_q == 3'b011)
            wide = {wide[61:0], 2'b00};
`endif
        // Upper halfwords do not exist in a 32-bit datapath.
        if (DATA_WIDTH == 32 && (ctrl_q == 3'b100 || ctrl_q == 3'b101) && hw[1]) begin
            wide  = '0;
            ill_d = 1'b1;
        end
        bus_d = wide[DATA_WIDTH-1:0];
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            ctrl_q <= '0;
            imm_q  <= '0;
            old_q  <= '0;
            tag1_q <= '0;
            bus_q  <= '0;
            tag2_q <= '0;
            ill_q  <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            if (s1_adv && InValid) begin
                ctrl_q <= Ctrl;
                imm_q  <= Imm26;
                old_q  <= BusOld;
                tag1_q <= InTag;
            end
            if (s2_adv && v1_q) begin
                bus_q  <= bus_d;
                tag2_q <= tag1_q;
                ill_q  <= ill_d;
            end
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: 64-bit and 32-bit instances side by side.
module tb_imm_extend_pipe;
    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic [2:0]  ctrl = '0;
    logic [25:0] imm = '0;
    logic [4:0]  tag = '0;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, illegal;
    logic [63:0] old = '0, bus;
    logic [4:0]  out_tag;

    logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b1, ill32;
    logic [31:0] old32 = '0, bus32;
    logic [4:0]  ot32;

    int tests = 0;
    int fails = 0;

`ifdef BRANCH_SHIFT_EN
    localparam logic [63:0] EXP_BNEG = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] EXP_BPOS = 64'h40;
    localparam logic [63:0] EXP_CBZ  = 64'hFFFF_FFFF_FFF0_0000;
    localparam logic [31:0] EXP_B32  = 32'hFFFF_FFFC;
`else
    localparam logic [63:0] EXP_BNEG = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] EXP_BPOS = 64'h10;
    localparam logic [63:0] EXP_CBZ  = 64'hFFFF_FFFF_FFFC_0000;
    localparam logic [31:0] EXP_B32  = 32'hFFFF_FFFF;
`endif

    imm_extend_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(5)) dut64 (
        .CLK(CLK), .Reset_L(Reset_L), .InValid(in_valid), .InReady(in_ready),
        .Imm26(imm), .Ctrl(ctrl), .BusOld(old), .InTag(tag),
        .OutValid(out_valid), .OutReady(out_ready), .BusImm(bus),
        .OutTag(out_tag), .Illegal(illegal));

    imm_extend_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut32 (
        .CLK(CLK), .Reset_L(Reset_L), .InValid(iv32), .InReady(ir32),
        .Imm26(imm), .Ctrl(ctrl), .BusOld(old32), .InTag(tag),
        .OutValid(ov32), .OutReady(or32), .BusImm(bus32),
        .OutTag(ot32), .Illegal(ill32));

    always #5 CLK = ~CLK;

    // Single request through the empty 64-bit pipe; ok = 0 if no result within the bound.
    task automatic xact64(input logic [2:0] c, input logic [25:0] im, input logic [63:0] od,
                          input logic [4:0] t, output logic [63:0] b, output logic [4:0] ot,
                          output logic il, output logic ok);
        int n;
        @(negedge CLK);
        ctrl = c; imm = im; old = od; tag = t; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 8) begin @(negedge CLK); n++; end
        ok = out_valid; b = bus; ot = out_tag; il = illegal;
    endtask

    task automatic xact32(input logic [2:0] c, input logic [25:0] im, input logic [31:0] od,
                          output logic [31:0] b, output logic il, output logic ok);
        int n;
        @(negedge CLK);
        ctrl = c; imm = im; old32 = od; tag = 5'd0; iv32 = 1'b1; or32 = 1'b1;
        @(negedge CLK);
        iv32 = 1'b0;
        n = 0;
        while (!ov32 && n < 8) begin @(negedge CLK); n++; end
        ok = ov32; b = bus32; il = ill32;
    endtask

    task automatic test_reset;
        // fill the pipe with OutReady low, then reset mid-cycle
        Reset_L = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0; ctrl = 3'b000; imm = 26'h3FFC00; tag = 5'd4; in_valid = 1'b1;
        @(negedge CLK);
        tag = 5'd5;
        @(negedge CLK);
        in_valid = 1'b0;
        tests++; if (!(out_valid && !in_ready)) begin fails++;
            $display("FAIL reset_prefill: ov=%0b ir=%0b want ov=1 ir=0", out_valid, in_ready); end
        #2 Reset_L = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || bus !== 64'd0 || out_tag !== 5'd0 || illegal !== 1'b0) begin fails++;
            $display("FAIL reset_outputs: ov=%0b bus=%h tag=%0d ill=%0b want all 0", out_valid, bus, out_tag, illegal); end
        tests++; if (in_ready !== 1'b1 || ir32 !== 1'b1) begin fails++;
            $display("FAIL reset_inready: ir=%0b ir32=%0b want 1", in_ready, ir32); end
        @(negedge CLK);
        Reset_L = 1'b1;
        out_ready = 1'b1; ctrl = 3'b000; imm = 26'h3FFC00; tag = 5'd9; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++;
            $display("FAIL reset_latency_gap: ov=%0b want 0", out_valid); end
        @(negedge CLK);
        tests++; if (out_valid !== 1'b1 || bus !== 64'hFFF || out_tag !== 5'd9) begin fails++;
            $display("FAIL reset_first_req: ov=%0b bus=%h tag=%0d want 1 fff 9", out_valid, bus, out_tag); end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back;
        @(negedge CLK);
        out_ready = 1'b1; ctrl = 3'b000; imm = 26'h3FFC00; tag = 5'd3; in_valid = 1'b1;
        @(negedge CLK);
        ctrl = 3'b001; imm = 26'h100000; tag = 5'd7;
        @(negedge CLK);
        ctrl = 3'b011; imm = 26'h0800000; tag = 5'd11;
        tests++; if (out_valid !== 1'b1 || bus !== 64'h0000_0000_0000_0FFF || out_tag !== 5'd3) begin fails++;
            $display("FAIL b2b_I: ov=%0b bus=%h tag=%0d want 1 fff 3", out_valid, bus, out_tag); end
        @(negedge CLK);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || bus !== 64'hFFFF_FFFF_FFFF_FF00 || out_tag !== 5'd7) begin fails++;
            $display("FAIL b2b_D: ov=%0b bus=%h tag=%0d want 1 ffffffffffffff00 7", out_valid, bus, out_tag); end
        @(negedge CLK);
        tests++; if (out_valid !== 1'b1 || bus !== EXP_CBZ || out_tag !== 5'd11) begin fails++;
            $display("FAIL b2b_CBZ: ov=%0b bus=%h tag=%0d want 1 %h 11", out_valid, bus, out_tag, EXP_CBZ); end
        @(negedge CLK);
        tests++; if (out_valid !== 1'b0) begin fails++;
            $display("FAIL b2b_drain: ov=%0b want 0", out_valid); end
    endtask

    task automatic test_branch;
        logic [63:0] b; logic [4:0] t; logic il, ok;
        xact64(3'b010, 26'h3FFFFFF, 64'd0, 5'd1, b, t, il, ok);
        tests++; if (!ok || b !== EXP_BNEG || il !== 1'b0) begin fails++;
            $display("FAIL branch_neg: ok=%0b bus=%h ill=%0b want %h 0", ok, b, il, EXP_BNEG); end
        xact64(3'b010, 26'h0000010, 64'd0, 5'd2, b, t, il, ok);
        tests++; if (!ok || b !== EXP_BPOS) begin fails++;
            $display("FAIL branch_pos: ok=%0b bus=%h want %h", ok, b, EXP_BPOS); end
    endtask

    task automatic test_movk_movz;
        logic [63:0] b; logic [4:0] t; logic il, ok;
        xact64(3'b101, 26'h57DDE0, 64'h1111_2222_3333_4444, 5'd6, b, t, il, ok);
        tests++; if (!ok || b !== 64'h1111_BEEF_3333_4444 || il !== 1'b0 || t !== 5'd6) begin fails++;
            $display("FAIL movk_hw2: ok=%0b bus=%h ill=%0b tag=%0d want 1111beef33334444 0 6", ok, b, il, t); end
        xact64(3'b100, 26'h57DDE0, 64'h1111_2222_3333_4444, 5'd8, b, t, il, ok);
        tests++; if (!ok || b !== 64'h0000_BEEF_0000_0000 || il !== 1'b0) begin fails++;
            $display("FAIL movz_hw2: ok=%0b bus=%h ill=%0b want 0000beef00000000 0", ok, b, il); end
        xact64(3'b100, 26'h77DDE0, 64'd0, 5'd8, b, t, il, ok);
        tests++; if (!ok || b !== 64'hBEEF_0000_0000_0000 || il !== 1'b0) begin fails++;
            $display("FAIL movz_hw3_64: ok=%0b bus=%h ill=%0b want beef000000000000 0", ok, b, il); end
        xact64(3'b110, 26'h3FFFFFF, 64'hFFFF, 5'd2, b, t, il, ok);
        tests++; if (!ok || b !== 64'd0 || il !== 1'b1) begin fails++;
            $display("FAIL reserved_110: ok=%0b bus=%h ill=%0b want 0 1", ok, b, il); end
    endtask

    task automatic test_width32;
        logic [31:0] b; logic il, ok;
        xact32(3'b100, 26'h77DDE0, 32'h0, b, il, ok);
        tests++; if (!ok || b !== 32'd0 || il !== 1'b1) begin fails++;
            $display("FAIL w32_movz_hw3: ok=%0b bus=%h ill=%0b want 0 1", ok, b, il); end
        xact32(3'b111, 26'h0, 32'h0, b, il, ok);
        tests++; if (!ok || b !== 32'd0 || il !== 1'b1) begin fails++;
            $display("FAIL w32_ctrl111: ok=%0b bus=%h ill=%0b want 0 1", ok, b, il); end
        xact32(3'b100, 26'h37DDE0, 32'h0, b, il, ok);
        tests++; if (!ok || b !== 32'hBEEF_0000 || il !== 1'b0) begin fails++;
            $display("FAIL w32_movz_hw1: ok=%0b bus=%h ill=%0b want beef0000 0", ok, b, il); end
        xact32(3'b101, 26'h37DDE0, 32'h3333_4444, b, il, ok);
        tests++; if (!ok || b !== 32'hBEEF_4444 || il !== 1'b0) begin fails++;
            $display("FAIL w32_movk_hw1: ok=%0b bus=%h ill=%0b want beef4444 0", ok, b, il); end
        xact32(3'b101, 26'h57DDE0, 32'h3333_4444, b, il, ok);
        tests++; if (!ok || b !== 32'd0 || il !== 1'b1) begin fails++;
            $display("FAIL w32_movk_hw2: ok=%0b bus=%h ill=%0b want 0 1", ok, b, il); end
        xact32(3'b001, 26'h100000, 32'h0, b, il, ok);
        tests++; if (!ok || b !== 32'hFFFF_FF00) begin fails++;
            $display("FAIL w32_D: ok=%0b bus=%h want ffffff00", ok, b); end
        xact32(3'b010, 26'h3FFFFFF, 32'h0, b, il, ok);
        tests++; if (!ok || b !== EXP_B32) begin fails++;
            $display("FAIL w32_B: ok=%0b bus=%h want %h", ok, b, EXP_B32); end
    endtask

    task automatic test_backpressure;
        @(negedge CLK);
        out_ready = 1'b0; ctrl = 3'b000; imm = 26'h400; tag = 5'd1; in_valid = 1'b1;
        tests++; if (in_ready !== 1'b1) begin fails++;
            $display("FAIL bp_ready0: ir=%0b want 1", in_ready); end
        @(negedge CLK);
        imm = 26'h800; tag = 5'd2;
        tests++; if (in_ready !== 1'b1) begin fails++;
            $display("FAIL bp_ready1: ir=%0b want 1", in_ready); end
        @(negedge CLK);
        imm = 26'hC00; tag = 5'd3;
        tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || bus !== 64'd1 || out_tag !== 5'd1) begin fails++;
            $display("FAIL bp_full: ir=%0b ov=%0b bus=%h tag=%0d want 0 1 1 1", in_ready, out_valid, bus, out_tag); end
        @(negedge CLK);
        tests++; if (in_ready !== 1'b0 || bus !== 64'd1 || out_tag !== 5'd1 || illegal !== 1'b0) begin fails++;
            $display("FAIL bp_hold: ir=%0b bus=%h tag=%0d want 0 1 1", in_ready, bus, out_tag); end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++;
            $display("FAIL bp_ready_comb: ir=%0b want 1", in_ready); end
        @(negedge CLK);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || bus !== 64'd2 || out_tag !== 5'd2) begin fails++;
            $display("FAIL bp_drain1: ov=%0b bus=%h tag=%0d want 1 2 2", out_valid, bus, out_tag); end
        @(negedge CLK);
        tests++; if (out_valid !== 1'b1 || bus !== 64'd3 || out_tag !== 5'd3) begin fails++;
            $display("FAIL bp_drain2: ov=%0b bus=%h tag=%0d want 1 3 3", out_valid, bus, out_tag); end
        @(negedge CLK);
        tests++; if (out_valid !== 1'b0) begin fails++;
            $display("FAIL bp_empty: ov=%0b want 0", out_valid); end
    endtask

    initial begin
        #12;
        test_reset();
        test_back_to_back();
        test_branch();
        test_movk_movz();
        test_width32();
        test_backpressure();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish before 100000");
        $fatal(1);
    end
endmodule
